fpga_cfg_loader: RTL and testbench

Configuration controller for the LUT/switch-box fabric model. Accepts a 16-word (32-bit) configuration stream over a valid/ready handshake and buffers it in a shadow store. Once complete, it commits the words to the 8 LUTs and 7 switch boxes through one-hot write strobes, then enables the fabric. This replaces hierarchical memory pokes with a synthesizable load path.

---
 rtl/fpga_cfg_pkg.sv | 41 ++++
 rtl/fpga_cfg_shadow.sv | 31 +++
 rtl/fpga_cfg_loader.sv | 170 +++++++++++++++++
 tb/tb_fpga_cfg_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared sizes, state encodings and index types for the fabric config loader.
// Build option: FPGA_CFG_CHECKSUM_EN appends a trailing XOR checksum word to the stream.
package fpga_cfg_pkg;

  localparam int unsigned NUM_LUTS  = 8;
  localparam int unsigned NUM_SB    = 7;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned CFG_WORDS = NUM_LUTS + NUM_SB + 1;
  localparam int unsigned MODE_WORD = 15;
  localparam int unsigned NUM_TGT   = NUM_LUTS + NUM_SB;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned STATE_W   = 3;

`ifdef FPGA_CFG_CHECKSUM_EN
  localparam int unsigned STREAM_WORDS = CFG_WORDS + 1;
`else
  localparam int unsigned STREAM_WORDS = CFG_WORDS;
`endif

  // Commit index (0..14) doubles as the shadow read address.
  typedef logic [ADDR_W-1:0] cidx_t;
  // Stream word index; one extra bit so the checksum word position fits.
  typedef logic [IDX_W-1:0]  widx_t;
  typedef logic [WORD_W-1:0] word_t;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD   = 3'd1;
  localparam logic [STATE_W-1:0] ST_COMMIT = 3'd2;
  localparam logic [STATE_W-1:0] ST_DONE   = 3'd3;
  localparam logic [STATE_W-1:0] ST_ERROR  = 3'd4;

  localparam widx_t LAST_IDX = widx_t'(STREAM_WORDS - 1);
  localparam cidx_t LAST_K   = cidx_t'(NUM_TGT - 1);

  // LUT k takes its mode bit from the MSB end of the mode word.
  function automatic logic [4:0] mode_bit(input cidx_t k);
    return 5'(WORD_W - 1) - 5'(k);
  endfunction

endpackage

// File: rtl/fpga_cfg_shadow.sv
// fpga_cfg_shadow: CFG_WORDS x WORD_W shadow store, one write port, commit and mode-word read ports.
module fpga_cfg_shadow
  import fpga_cfg_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rd_data_c_o,
  output logic [WORD_W-1:0] mode_word_c_o
);

  word_t mem_q [CFG_WORDS];

  // Capture accepted stream words; reset clears the whole store.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(CFG_WORDS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rd_data_c_o   = mem_q[raddr_i];
  assign mode_word_c_o = mem_q[MODE_WORD];

endmodule

// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: buffers a valid/ready config stream, then commits it to LUTs and switch
// boxes with one-hot strobes before enabling the fabric.
// Build option: FPGA_CFG_CHECKSUM_EN adds a trailing XOR checksum word and the ERROR state.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                word_valid_i,
  input  logic [WORD_W-1:0]   word_data_i,
  output logic                word_ready_o,
  output logic [NUM_LUTS-1:0] lut_we_o,
  output logic [WORD_W:0]     lut_data_o,
  output logic [NUM_SB-1:0]   sb_we_o,
  output logic [WORD_W-1:0]   sb_data_o,
  output logic                fabric_en_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o
);

  logic [STATE_W-1:0]  state_q, state_d;
  widx_t               idx_q, idx_d;
  cidx_t               k_q, k_d;
  logic                last_q, last_d;
  logic [NUM_LUTS-1:0] lut_we_q, lut_we_d;
  logic [WORD_W:0]     lut_data_q, lut_data_d;
  logic [NUM_SB-1:0]   sb_we_q, sb_we_d;
  logic [WORD_W-1:0]   sb_data_q, sb_data_d;
  logic                word_ready_q, busy_q, done_q;
  logic                shadow_we_c;
  word_t               rd_data_c, mode_word_c;
`ifdef FPGA_CFG_CHECKSUM_EN
  word_t               csum_q, csum_d;
  logic                error_q;
`endif

  fpga_cfg_shadow u_shadow (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .we_i          (shadow_we_c),
    .waddr_i       (cidx_t'(idx_q)),
    .wdata_i       (word_data_i),
    .raddr_i       (k_q),
    .rd_data_c_o   (rd_data_c),
    .mode_word_c_o (mode_word_c)
  );

  // Next-state, index and strobe decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    k_d         = k_q;
    last_d      = last_q;
    lut_we_d    = '0;
    sb_we_d     = '0;
    lut_data_d  = lut_data_q;
    sb_data_d   = sb_data_q;
    shadow_we_c = 1'b0;
`ifdef FPGA_CFG_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_i) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          k_d     = '0;
          last_d  = 1'b0;
`ifdef FPGA_CFG_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      ST_LOAD: begin
        if (word_valid_i && word_ready_q) begin
`ifdef FPGA_CFG_CHECKSUM_EN
          if (idx_q == LAST_IDX) begin
            state_d = (word_data_i == csum_q) ? ST_COMMIT : ST_ERROR;
          end else begin
            shadow_we_c = 1'b1;
            csum_d      = csum_q ^ word_data_i;
            idx_d       = idx_q + 1'b1;
          end
`else
          shadow_we_c = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_COMMIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
`endif
        end
      end
      ST_COMMIT: begin
        if (last_q) begin
          state_d = ST_DONE;
        end else begin
          if (k_q < cidx_t'(NUM_LUTS)) begin
            lut_we_d[3'(k_q)] = 1'b1;
            lut_data_d        = {mode_word_c[mode_bit(k_q)], rd_data_c};
          end else begin
            sb_we_d[3'(k_q - cidx_t'(NUM_LUTS))] = 1'b1;
            sb_data_d                            = rd_data_c;
          end
          if (k_q == LAST_K) begin
            last_d = 1'b1;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, indices and registered outputs; status flags follow the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      k_q          <= '0;
      last_q       <= 1'b0;
      lut_we_q     <= '0;
      lut_data_q   <= '0;
      sb_we_q      <= '0;
      sb_data_q    <= '0;
      word_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef FPGA_CFG_CHECKSUM_EN
      csum_q       <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      k_q          <= k_d;
      last_q       <= last_d;
      lut_we_q     <= lut_we_d;
      lut_data_q   <= lut_data_d;
      sb_we_q      <= sb_we_d;
      sb_data_q    <= sb_data_d;
      word_ready_q <= (state_d == ST_LOAD);
      busy_q       <= (state_d == ST_LOAD) || (state_d == ST_COMMIT);
      done_q       <= (state_d == ST_DONE);
`ifdef FPGA_CFG_CHECKSUM_EN
      csum_q       <= csum_d;
      error_q      <= (state_d == ST_ERROR);
`endif
    end
  end

  assign word_ready_o = word_ready_q;
  assign lut_we_o     = lut_we_q;
  assign lut_data_o   = lut_data_q;
  assign sb_we_o      = sb_we_q;
  assign sb_data_o    = sb_data_q;
  // The fabric runs exactly while the loader sits in DONE.
  assign fabric_en_o  = done_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
`ifdef FPGA_CFG_CHECKSUM_EN
  assign error_o      = error_q;
`else
  assign error_o      = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb_fpga_cfg_loader: scoreboard bench for the config loader; expected strobes are queued
// when a stream is driven and popped as the loader issues them.
module tb_fpga_cfg_loader;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        word_valid_i = 1'b0;
  logic [31:0] word_data_i = '0;
  logic        word_ready_o;
  logic [7:0]  lut_we_o;
  logic [32:0] lut_data_o;
  logic [6:0]  sb_we_o;
  logic [31:0] sb_data_o;
  logic        fabric_en_o, busy_o, done_o, error_o;

  fpga_cfg_loader dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .word_valid_i (word_valid_i),
    .word_data_i  (word_data_i),
    .word_ready_o (word_ready_o),
    .lut_we_o     (lut_we_o),
    .lut_data_o   (lut_data_o),
    .sb_we_o      (sb_we_o),
    .sb_data_o    (sb_data_o),
    .fabric_en_o  (fabric_en_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [47:0] pkt;
    logic [31:0] cyc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] cyc = '0;
  logic [31:0] w [16];
  logic [31:0] e_edge;
  logic [47:0] mon_got;
  exp_t        mon_e;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every strobe the DUT issues must match the head of the scoreboard, in content and cycle.
  always @(negedge clk_i) begin
    if (!rst_i && (lut_we_o != '0 || sb_we_o != '0)) begin
      mon_got = {lut_we_o, sb_we_o, (lut_we_o != '0) ? lut_data_o : {1'b0, sb_data_o}};
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", 64'(mon_got), 64'h0);
      end else begin
        mon_e = sb_q.pop_front();
        check("strobe", 64'(mon_got), 64'(mon_e.pkt));
        check("strobe_cyc", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic push_expected(input logic [31:0] acc_edge);
    exp_t        e;
    logic [31:0] mw;
    mw = w[15];
    for (int n = 0; n < 15; n++) begin
      if (n < 8) e.pkt = {8'(1 << n), 7'd0, mw[31-n], w[n]};
      else       e.pkt = {8'd0, 7'(1 << (n - 8)), 1'b0, w[n]};
      e.cyc = acc_edge + 1 + 32'(n);
      sb_q.push_back(e);
    end
  endtask

  // Start (with a stray word in the same cycle), stream 16 words (+checksum), queue expectations.
  task automatic send_stream(input bit toggle, input bit poke_start, input bit bad_csum,
                             output logic [31:0] acc_edge);
    logic [31:0] csum;
    csum = '0;
    @(negedge clk_i);
    start_i = 1'b1; word_valid_i = 1'b1; word_data_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    start_i = 1'b0; word_valid_i = 1'b0;
    check("ready_after_start", 64'(word_ready_o), 64'd1);
    check("busy_after_start", 64'(busy_o), 64'd1);
    check("fabric_en_after_start", 64'(fabric_en_o), 64'd0);
    check("error_after_start", 64'(error_o), 64'd0);
    for (int i = 0; i < 16; i++) begin
      if (toggle) begin
        word_valid_i = 1'b0;
        @(negedge clk_i);
      end
      word_valid_i = 1'b1; word_data_i = w[i];
      csum = csum ^ w[i];
      if (poke_start && i == 5) start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
    end
`ifdef FPGA_CFG_CHECKSUM_EN
    word_valid_i = 1'b1; word_data_i = bad_csum ? (csum ^ 32'h1) : csum;
    @(negedge clk_i);
`endif
    word_valid_i = 1'b0;
    acc_edge = cyc;
    check("ready_after_last", 64'(word_ready_o), 64'd0);
    if (!bad_csum) push_expected(acc_edge);
  endtask

  task automatic wait_done(input logic [31:0] acc_edge, input bit poke);
    int budget;
    budget = 0;
    while (done_o !== 1'b1 && budget < 40) begin
      if (poke && cyc == acc_edge + 5) begin
        start_i = 1'b1; word_valid_i = 1'b1; word_data_i = 32'h1234_5678;
      end
      @(negedge clk_i);
      start_i = 1'b0; word_valid_i = 1'b0;
      budget++;
    end
    check("done_cycle", 64'(cyc), 64'(acc_edge + 16));
    check("fabric_en_done", 64'(fabric_en_o), 64'd1);
    check("busy_done", 64'(busy_o), 64'd0);
    check("queue_drained", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic set_counter();
    for (int i = 0; i < 16; i++) w[i] = 32'(i) * 32'h0101_0101 + 32'h0400_0000;
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    check("rst_ready", 64'(word_ready_o), 64'd0);
    check("rst_lut_we", 64'(lut_we_o), 64'd0);
    check("rst_sb_we", 64'(sb_we_o), 64'd0);
    check("rst_lut_data", 64'(lut_data_o), 64'd0);
    check("rst_sb_data", 64'(sb_data_o), 64'd0);
    check("rst_flags", 64'({fabric_en_o, busy_o, done_o, error_o}), 64'd0);
    rst_i = 1'b0;
    word_valid_i = 1'b1; word_data_i = 32'hBAD0_0001;
    @(negedge clk_i);
    word_valid_i = 1'b0;
    check("idle_valid_ignored", 64'({word_ready_o, busy_o}), 64'd0);

    // Counter bitstream, valid held high.
    set_counter();
    send_stream(1'b0, 1'b0, 1'b0, e_edge);
    wait_done(e_edge, 1'b0);

    // Restart from DONE with all-ones words.
    for (int i = 0; i < 16; i++) w[i] = '1;
    send_stream(1'b0, 1'b0, 1'b0, e_edge);
    wait_done(e_edge, 1'b0);

    // Valid toggling every other cycle.
    set_counter();
    send_stream(1'b1, 1'b0, 1'b0, e_edge);
    wait_done(e_edge, 1'b0);

    // Stray start/valid during LOAD and COMMIT.
    for (int i = 0; i < 16; i++) w[i] = $urandom;
    send_stream(1'b0, 1'b1, 1'b0, e_edge);
    wait_done(e_edge, 1'b1);

    // Reset while committing LUT 3.
    set_counter();
    send_stream(1'b0, 1'b0, 1'b0, e_edge);
    repeat (4) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("midrst_strobes", 64'({lut_we_o, sb_we_o}), 64'd0);
    check("midrst_data", 64'({lut_data_o, sb_data_o}), 64'd0);
    check("midrst_flags", 64'({word_ready_o, fabric_en_o, busy_o, done_o, error_o}), 64'd0);
    sb_q.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (20) @(negedge clk_i);
    check("post_rst_idle", 64'({word_ready_o, fabric_en_o, busy_o, done_o}), 64'd0);

`ifdef FPGA_CFG_CHECKSUM_EN
    // Corrupted checksum word lands in ERROR with no strobes.
    set_counter();
    send_stream(1'b0, 1'b0, 1'b1, e_edge);
    check("csum_error", 64'(error_o), 64'd1);
    check("csum_fabric_en", 64'(fabric_en_o), 64'd0);
    repeat (20) @(negedge clk_i);
    check("csum_error_hold", 64'({error_o, done_o, busy_o}), 64'b100);
    send_stream(1'b0, 1'b0, 1'b0, e_edge);
    wait_done(e_edge, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
